// File: rtl/uart_debug_ctrl_if.sv
// Signal bundle between uart_debug_ctrl and its surroundings: UART RX/TX FIFO
// handshakes plus the pipeline run/step/dump controls.
interface uart_debug_ctrl_if #(
    parameter int AW = 5
);
    logic          rx_empty;
    logic [7:0]    r_data;
    logic          rd_uart;
    logic          tx_full;
    logic [7:0]    w_data;
    logic          wr_uart;
    logic          halt;
    logic          run_en;
    logic          step;
    logic [31:0]   pc_in;
    logic [AW-1:0] dump_addr;
    logic [31:0]   dump_data;

    modport master (
        input  rx_empty, r_data, tx_full, halt, pc_in, dump_data,
        output rd_uart, w_data, wr_uart, run_en, step, dump_addr
    );

    modport slave (
        output rx_empty, r_data, tx_full, halt, pc_in, dump_data,
        input  rd_uart, w_data, wr_uart, run_en, step, dump_addr
    );
endinterface

// File: rtl/uart_debug_ctrl.sv
// Serial debug command engine: pops 'c'/'s'/'d' from the RX FIFO, runs/steps/dumps
// the pipeline and returns 32-bit words LSB first. Optional echo: UART_DBG_ECHO_EN.
module uart_debug_ctrl #(
    parameter int         NWORDS   = 32,
    parameter int         AW       = 5,
    parameter logic [7:0] CMD_RUN  = 8'h63,
    parameter logic [7:0] CMD_STEP = 8'h73,
    parameter logic [7:0] CMD_DUMP = 8'h64
) (
    input logic               clk,
    input logic               rst,
    uart_debug_ctrl_if.master bus
);

`ifdef UART_DBG_ECHO_EN
    typedef enum logic [2:0] {IDLE, DECODE, ECHO, RUN, STEP, LOAD, SEND} state_t;
`else
    typedef enum logic [2:0] {IDLE, DECODE, RUN, STEP, LOAD, SEND} state_t;
`endif

    state_t        state, state_nxt, target;
    logic [7:0]    cmd;
    logic [31:0]   cyc_cnt;
    logic [31:0]   shift;
    logic [31:0]   load_word;
    logic [1:0]    byte_idx;
    logic [AW-1:0] dump_addr;
    logic          last_word;
    logic          dispatch;
    logic          word_done;
    logic          rd_uart_c, wr_uart_c, run_en_c, step_c;
    logic [7:0]    w_data_c;

    assign last_word = (dump_addr == AW'(NWORDS - 1));

    always_comb begin
        case (cmd)
            CMD_RUN:  load_word = cyc_cnt;
            CMD_STEP: load_word = bus.pc_in;
            default:  load_word = bus.dump_data;
        endcase
    end

    always_comb begin
        case (cmd)
            CMD_RUN:  target = RUN;
            CMD_STEP: target = STEP;
            CMD_DUMP: target = LOAD;
            default:  target = IDLE;
        endcase
    end

    always_comb begin
        state_nxt = state;
        rd_uart_c = 1'b0;
        wr_uart_c = 1'b0;
        w_data_c  = 8'h00;
        run_en_c  = 1'b0;
        step_c    = 1'b0;
        dispatch  = 1'b0;
        word_done = 1'b0;
        case (state)
            // Pop is gated by rst so no byte leaves the FIFO while it cannot be latched
            IDLE: begin
                if (rst && !bus.rx_empty) begin
                    rd_uart_c = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
`ifdef UART_DBG_ECHO_EN
                state_nxt = ECHO;
`else
                dispatch  = 1'b1;
                state_nxt = target;
`endif
            end
`ifdef UART_DBG_ECHO_EN
            ECHO: begin
                if (!bus.tx_full) begin
                    wr_uart_c = 1'b1;
                    w_data_c  = cmd;
                    dispatch  = 1'b1;
                    state_nxt = target;
                end
            end
`endif
            RUN: begin
                if (bus.halt) state_nxt = LOAD;
                else          run_en_c  = 1'b1;
            end
            STEP: begin
                step_c    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                if (!bus.tx_full) begin
                    wr_uart_c = 1'b1;
                    w_data_c  = shift[7:0];
                    if (byte_idx == 2'd3) begin
                        word_done = 1'b1;
                        state_nxt = (cmd == CMD_DUMP && !last_word) ? LOAD : IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd       <= 8'h00;
            cyc_cnt   <= 32'h0;
            shift     <= 32'h0;
            byte_idx  <= 2'd0;
            dump_addr <= '0;
        end else begin
            state <= state_nxt;
            if (rd_uart_c) cmd <= bus.r_data;
            if (dispatch && cmd == CMD_RUN) cyc_cnt <= 32'h0;
            else if (run_en_c)              cyc_cnt <= cyc_cnt + 32'd1;
            // dump_addr advances at the end of a word so it is settled through the next LOAD
            if (dispatch && cmd == CMD_DUMP)       dump_addr <= '0;
            else if (word_done && cmd == CMD_DUMP) dump_addr <= last_word ? '0 : dump_addr + 1'b1;
            if (state == LOAD) begin
                shift    <= load_word;
                byte_idx <= 2'd0;
            end else if (state == SEND && wr_uart_c) begin
                shift    <= {8'h00, shift[31:8]};
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    assign bus.rd_uart   = rd_uart_c;
    assign bus.wr_uart   = wr_uart_c;
    assign bus.w_data    = w_data_c;
    assign bus.run_en    = run_en_c;
    assign bus.step      = step_c;
    assign bus.dump_addr = dump_addr;

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Scoreboard bench for uart_debug_ctrl: RX/TX FIFO models, expected TX bytes
// queued at stimulus time and checked by a negedge monitor.
module tb_uart_debug_ctrl;
    localparam int NW = 4;
    localparam int AW = 2;
`ifdef UART_DBG_ECHO_EN
    localparam int E = 1;
`else
    localparam int E = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_debug_ctrl_if #(.AW(AW)) bus ();
    uart_debug_ctrl #(.NWORDS(NW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.dump_data = 32'hA0 + 32'(bus.dump_addr);

    int         tests = 0;
    int         fails = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int         byte_cyc[$];
    int         cyc = 0;
    int         step_cnt = 0;
    int         run_cnt = 0;
    int         pop_cyc = 0;
    int         step_cyc = 0;
    bit         pop_req = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic upd_rx();
        bus.rx_empty = (rxq.size() == 0);
        bus.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rxq.push_back(b);
        upd_rx();
`ifdef UART_DBG_ECHO_EN
        expq.push_back(b);
`endif
    endtask

    task automatic exp_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) expq.push_back(w[8*i +: 8]);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || rxq.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({name, " all bytes"}, expq.size(), 0);
    endtask

    // Monitor: sample DUT outputs mid-cycle, score TX pushes
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (rst) begin
            if (bus.rd_uart) begin
                if (bus.rx_empty) begin
                    fails++;
                    $display("FAIL rd_uart_on_empty: got 1 required 0");
                end
                pop_req = 1;
                pop_cyc = cyc;
            end
            if (bus.step) begin
                step_cnt++;
                step_cyc = cyc;
            end
            if (bus.run_en) run_cnt++;
            if (bus.run_en && bus.halt) begin
                fails++;
                $display("FAIL run_en_with_halt: got 1 required 0");
            end
            if (bus.wr_uart) begin
                tests++;
                if (bus.tx_full) begin
                    fails++;
                    $display("FAIL wr_uart_on_full: got 1 required 0");
                end
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL tx_byte: got %02h required no byte", bus.w_data);
                end else begin
                    e = expq.pop_front();
                    if (bus.w_data !== e) begin
                        fails++;
                        $display("FAIL tx_byte: got %02h required %02h", bus.w_data, e);
                    end
                end
                byte_cyc.push_back(cyc);
            end
        end
    end

    // RX FIFO model: pop after the edge that consumed the head
    always @(posedge clk) begin
        #1;
        if (pop_req) begin
            if (rxq.size() != 0) rxq.delete(0);
            pop_req = 0;
        end
        upd_rx();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, bb, rb, n;
        bus.tx_full = 1'b0;
        bus.halt    = 1'b0;
        bus.pc_in   = 32'h0000_0040;
        upd_rx();
        repeat (3) tick();
        chk("reset rd_uart", bus.rd_uart, 0);
        chk("reset wr_uart", bus.wr_uart, 0);
        chk("reset w_data", bus.w_data, 0);
        chk("reset run_en", bus.run_en, 0);
        chk("reset step", bus.step, 0);
        chk("reset dump_addr", bus.dump_addr, 0);
        rst = 1'b1;
        tick();

        // Single step, PC 0x40
        sb = step_cnt; bb = byte_cyc.size();
        send_cmd(8'h73);
        exp_word(32'h0000_0040);
        drain("step");
        chk("step pulses", step_cnt - sb, 1);
        chk("step pulse latency", step_cyc - pop_cyc, 2 + E);
        chk("step first byte latency", byte_cyc[bb+E] - pop_cyc, 4 + E);
        chk("step byte spacing", byte_cyc[bb+E+3] - byte_cyc[bb+E], 3);

        // Run 10 cycles then halt
        rb = run_cnt;
        send_cmd(8'h63);
        exp_word(32'h0000_000A);
        n = 0;
        while (run_cnt - rb < 10 && n < 100) begin tick(); n++; end
        chk("run_en cycles", run_cnt - rb, 10);
        bus.halt = 1'b1;
        #1;
        chk("run_en at halt", bus.run_en, 0);
        drain("run");
        bus.halt = 1'b0;

        // Run with halt already high: result 0, no run_en
        bus.halt = 1'b1;
        rb = run_cnt;
        send_cmd(8'h63);
        exp_word(32'h0);
        drain("run halted");
        chk("run halted run_en", run_cnt - rb, 0);
        bus.halt = 1'b0;

        // Dump 4 words
        send_cmd(8'h64);
        for (int k = 0; k < NW; k++) exp_word(32'hA0 + k);
        drain("dump");
        chk("dump_addr after dump", bus.dump_addr, 0);

        // Step response stalled by tx_full for 20 cycles
        bus.pc_in = 32'h1234_5678;
        bb = byte_cyc.size();
        send_cmd(8'h73);
        exp_word(32'h1234_5678);
        n = 0;
        while (byte_cyc.size() < bb + E + 1 && n < 50) begin tick(); n++; end
        bus.tx_full = 1'b1;
        bb = byte_cyc.size();
        repeat (20) tick();
        chk("no push while full", byte_cyc.size() - bb, 0);
        bus.tx_full = 1'b0;
        drain("step stalled");

        // Unknown byte followed by step
        bus.pc_in = 32'h0000_0080;
        sb = step_cnt;
        send_cmd(8'h55);
        send_cmd(8'h73);
        exp_word(32'h0000_0080);
        drain("unknown then step");
        chk("unknown then step pulses", step_cnt - sb, 1);

        // Reset during byte 2 of a dump
        bb = byte_cyc.size();
        send_cmd(8'h64);
        expq.push_back(8'hA0);
        expq.push_back(8'h00);
        n = 0;
        while (byte_cyc.size() < bb + E + 2 && n < 50) begin tick(); n++; end
        rst = 1'b0;
        #1;
        chk("abort wr_uart", bus.wr_uart, 0);
        chk("abort w_data", bus.w_data, 0);
        chk("abort dump_addr", bus.dump_addr, 0);
        chk("abort run_en", bus.run_en, 0);
        chk("abort step", bus.step, 0);
        chk("abort rd_uart", bus.rd_uart, 0);
        pop_req = 0;
        bb = byte_cyc.size();
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("no bytes after abort", byte_cyc.size() - bb, 0);
        bus.pc_in = 32'h0000_0044;
        sb = step_cnt;
        send_cmd(8'h73);
        exp_word(32'h0000_0044);
        drain("step after reset");
        chk("step after reset pulses", step_cnt - sb, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
